// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle for the branch predictor: lookup, training and perf counters.
interface branch_predictor_if;
    logic        bp_enable;
    logic        bp_flush;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    // Pipeline side: drives fetch PC and resolution reports, consumes predictions.
    modport master (
        output bp_enable, bp_flush, fetch_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  pred_taken, pred_target, br_count, mispred_count
    );

    // Predictor side.
    modport slave (
        input  bp_enable, bp_flush, fetch_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output pred_taken, pred_target, br_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; training and perf counters update on the rising edge.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bus
);
    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = 30 - IDX;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [TAGW-1:0]    tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        br_count_q, br_count_d;
    logic [31:0]        mispred_count_q, mispred_count_d;

    logic [IDX-1:0]  fetch_idx, upd_idx;
    logic [TAGW-1:0] fetch_tag, upd_tag;
    logic            fetch_hit, upd_hit;

    assign fetch_idx = bus.fetch_pc[IDX+1:2];
    assign fetch_tag = bus.fetch_pc[31:IDX+2];
    assign upd_idx   = bus.upd_pc[IDX+1:2];
    assign upd_tag   = bus.upd_pc[31:IDX+2];

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

    // Lookup against registered state only, so a same-cycle update is not visible.
    always_comb begin
        fetch_hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        upd_hit         = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        bus.pred_taken  = bus.bp_enable && fetch_hit && ctr_q[fetch_idx][1];
        bus.pred_target = fetch_hit ? target_q[fetch_idx] : bus.fetch_pc + 32'd4;
    end

    assign bus.br_count      = br_count_q;
    assign bus.mispred_count = mispred_count_q;

    // Next-state for table training, allocation, flush and perf counters.
    always_comb begin
        valid_d         = valid_q;
        tag_d           = tag_q;
        target_d        = target_q;
        ctr_d           = ctr_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (bus.upd_valid) begin
            br_count_d      = br_count_q + 32'd1;
            mispred_count_d = mispred_count_q + {31'd0, bus.upd_mispredict};
            if (upd_hit) begin
                if (bus.upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
                    end
                    target_d[upd_idx] = bus.upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
                end
            end else if (bus.upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bus.upd_target;
                ctr_d[upd_idx]    = 2'b10;
            end
        end
        // Flush wins over a same-cycle allocate.
        if (bus.bp_flush) begin
            valid_d = '0;
        end
    end

    // Valid bits, counters and perf counters: synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q         <= '0;
            ctr_q           <= '{default: 2'b01};
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            valid_q         <= valid_d;
            ctr_q           <= ctr_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed table, hand sequences, then randomized run against a model.
module tb_branch_predictor;
    localparam int unsigned ENTRIES = 16;

    logic clk;
    logic rst_n;
    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: each slot remembers the full word address it was trained on.
    bit          m_valid [ENTRIES];
    logic [29:0] m_word  [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_br, m_mis;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_word[slot(pc)] == pc[31:2]);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            m_br  = 0;
            m_mis = 0;
        end else begin
            if (bp_if.upd_valid) begin
                int s;
                s = slot(bp_if.upd_pc);
                m_br  = m_br + 1;
                m_mis = m_mis + (bp_if.upd_mispredict ? 1 : 0);
                if (m_hit(bp_if.upd_pc)) begin
                    if (bp_if.upd_taken) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = bp_if.upd_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (bp_if.upd_taken) begin
                    m_valid[s] = 1;
                    m_word[s]  = bp_if.upd_pc[31:2];
                    m_tgt[s]   = bp_if.upd_target;
                    m_ctr[s]   = 2;
                end
            end
            if (bp_if.bp_flush) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            end
        end
    end

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        fl;
        logic        en;
        logic [31:0] fpc;
        logic        exp_tk;
        logic [31:0] exp_tgt;
    } vec_t;

    localparam logic [31:0] PA = 32'h4000_0010;
    localparam logic [31:0] PB = 32'h4000_0050;
    localparam logic [31:0] PC = 32'h4000_0020;
    localparam logic [31:0] TA = 32'h4000_0100;
    localparam logic [31:0] TB = 32'h4000_0200;
    localparam logic [31:0] TC = 32'h4000_0300;

    vec_t tbl [16];

    task automatic idle();
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_mispredict = 1'b0;
        bp_if.upd_pc         = '0;
        bp_if.upd_target     = '0;
        bp_if.bp_flush       = 1'b0;
        bp_if.bp_enable      = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic mis);
        bp_if.upd_valid      = 1'b1;
        bp_if.upd_pc         = pc;
        bp_if.upd_taken      = tk;
        bp_if.upd_target     = tgt;
        bp_if.upd_mispredict = mis;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        edge_step();
        edge_step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bp_if.fetch_pc = 32'h4000_0000;

        // Reset held two cycles with an allocate in flight: it must be discarded.
        @(negedge clk);
        upd(32'h4000_0000, 1'b1, 32'h1234_0000, 1'b1);
        edge_step();
        edge_step();
        rst_n = 1'b1;
        idle();
        bp_if.fetch_pc = 32'h4000_0000;
        @(negedge clk);
        chk("reset pred_taken", {31'd0, bp_if.pred_taken}, 32'd0);
        chk("reset pred_target", bp_if.pred_target, 32'h4000_0004);
        chk("reset br_count", bp_if.br_count, 32'd0);
        chk("reset mispred_count", bp_if.mispred_count, 32'd0);
        edge_step();

        // Allocate is invisible during its own cycle, visible on the next.
        upd(PA, 1'b1, TA, 1'b0);
        bp_if.fetch_pc = PA;
        @(negedge clk);
        chk("same-cycle pred_taken", {31'd0, bp_if.pred_taken}, 32'd0);
        chk("same-cycle pred_target", bp_if.pred_target, PA + 32'd4);
        edge_step();
        idle();
        @(negedge clk);
        chk("post-alloc pred_taken", {31'd0, bp_if.pred_taken}, 32'd1);
        chk("post-alloc pred_target", bp_if.pred_target, TA);
        do_reset();

        // Directed table: each row updates, then its fetch is checked the next cycle.
        tbl[0]  = '{1'b1, PA, 1'b1, TA, 1'b0, 1'b1, PA, 1'b1, TA};
        tbl[1]  = '{1'b1, PA, 1'b0, TC, 1'b0, 1'b1, PA, 1'b0, TA};
        tbl[2]  = '{1'b1, PA, 1'b0, TC, 1'b0, 1'b1, PA, 1'b0, TA};
        tbl[3]  = '{1'b1, PA, 1'b0, TC, 1'b0, 1'b1, PA, 1'b0, TA};
        tbl[4]  = '{1'b1, PA, 1'b1, TA, 1'b0, 1'b1, PA, 1'b0, TA};
        tbl[5]  = '{1'b1, PA, 1'b1, TA, 1'b0, 1'b1, PA, 1'b1, TA};
        tbl[6]  = '{1'b1, PA, 1'b1, TA, 1'b0, 1'b1, PA, 1'b1, TA};
        tbl[7]  = '{1'b1, PA, 1'b1, TA, 1'b0, 1'b1, PA, 1'b1, TA};
        tbl[8]  = '{1'b1, PA, 1'b1, TA, 1'b0, 1'b1, PA, 1'b1, TA};
        tbl[9]  = '{1'b1, PA, 1'b1, TA, 1'b0, 1'b1, PA, 1'b1, TA};
        tbl[10] = '{1'b1, PA, 1'b0, TC, 1'b0, 1'b1, PA, 1'b1, TA};
        tbl[11] = '{1'b1, PB, 1'b1, TB, 1'b0, 1'b1, PA, 1'b0, PA + 32'd4};
        tbl[12] = '{1'b0, PB, 1'b0, TC, 1'b0, 1'b1, PB, 1'b1, TB};
        tbl[13] = '{1'b0, PB, 1'b0, TC, 1'b0, 1'b0, PB, 1'b0, TB};
        tbl[14] = '{1'b1, PC, 1'b1, TC, 1'b1, 1'b1, PC, 1'b0, PC + 32'd4};
        tbl[15] = '{1'b0, PB, 1'b0, TC, 1'b0, 1'b1, PB, 1'b0, PB + 32'd4};
        for (int i = 0; i < 16; i++) begin
            idle();
            if (tbl[i].uv) upd(tbl[i].upc, tbl[i].ut, tbl[i].utgt, 1'b0);
            bp_if.bp_flush = tbl[i].fl;
            edge_step();
            idle();
            bp_if.bp_enable = tbl[i].en;
            bp_if.fetch_pc  = tbl[i].fpc;
            @(negedge clk);
            chk($sformatf("row%0d pred_taken", i), {31'd0, bp_if.pred_taken},
                {31'd0, tbl[i].exp_tk});
            chk($sformatf("row%0d pred_target", i), bp_if.pred_target, tbl[i].exp_tgt);
            edge_step();
        end
        idle();

        // Perf counters over five resolutions, then a reset with an update in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            upd(32'h8000_0000 + 32'(i * 4), 1'b0, 32'd0, (i == 0 || i == 2 || i == 3));
            edge_step();
        end
        idle();
        @(negedge clk);
        chk("br_count after 5", bp_if.br_count, 32'd5);
        chk("mispred_count after 5", bp_if.mispred_count, 32'd3);
        edge_step();
        rst_n = 1'b0;
        upd(PA, 1'b1, TA, 1'b1);
        edge_step();
        @(negedge clk);
        chk("mid-reset br_count", bp_if.br_count, 32'd0);
        chk("mid-reset mispred_count", bp_if.mispred_count, 32'd0);
        rst_n = 1'b1;
        idle();
        bp_if.fetch_pc = PA;
        @(negedge clk);
        chk("mid-reset lookup miss", bp_if.pred_target, PA + 32'd4);
        edge_step();

        // Randomized traffic over a small PC window so hits and aliases are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] fpc;
            logic        exp_tk;
            logic [31:0] exp_tgt;
            rst_n                = ($urandom_range(0, 299) != 0);
            bp_if.bp_enable      = ($urandom_range(0, 7) != 0);
            bp_if.bp_flush       = ($urandom_range(0, 49) == 0);
            bp_if.upd_valid      = ($urandom_range(0, 3) != 0);
            bp_if.upd_pc         = 32'h4000_0000 | (32'($urandom_range(0, 47)) << 2)
                                   | 32'($urandom_range(0, 3));
            bp_if.upd_taken      = $urandom_range(0, 2) != 0;
            bp_if.upd_target     = $urandom;
            bp_if.upd_mispredict = $urandom_range(0, 1) != 0;
            fpc = 32'h4000_0000 | (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            bp_if.fetch_pc = fpc;
            @(negedge clk);
            exp_tk  = bp_if.bp_enable && m_hit(fpc) && (m_ctr[slot(fpc)] >= 2);
            exp_tgt = m_hit(fpc) ? m_tgt[slot(fpc)] : fpc + 32'd4;
            chk("rand pred_taken", {31'd0, bp_if.pred_taken}, {31'd0, exp_tk});
            chk("rand pred_target", bp_if.pred_target, exp_tgt);
            chk("rand br_count", bp_if.br_count, m_br);
            chk("rand mispred_count", bp_if.mispred_count, m_mis);
            edge_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Branch target buffer with 2-bit saturating direction counters.
- Feeds the fetch next-PC mux with a taken prediction and a predicted target for the PC being fetched.
- Trains from branch resolution reported by execute.
- Direct-mapped, register-based table; zero-cycle lookup, one-cycle update; includes branch/mispredict performance counters readable by CSR logic.

## Interface

Parameters:
- `ENTRIES`, default 16: table depth; power of two, ≥2. `IDX = log2(ENTRIES)`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `bp_enable`  in  1  1 = predictions driven; 0 = `pred_taken` forced 0 (training continues).
- `bp_flush`  in  1  clear all entry valid bits at next edge.
- `fetch_pc`  in  32  PC being fetched.
- `pred_taken`  out  1  predicted taken for `fetch_pc`.
- `pred_target`  out  32  predicted next PC for `fetch_pc`.
- `upd_valid`  in  1  a conditional branch resolved this cycle.
- `upd_pc`  in  32  PC of resolved branch.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  32  actual taken target (ALU result).
- `upd_mispredict`  in  1  fetch mispredicted this branch; qualified by `upd_valid`.
- `br_count`  out  32  resolved branches since reset.
- `mispred_count`  out  32  mispredictions since reset.

## Operation

- Entry state: `valid` (1), `tag` (32-2-IDX), `target` (32), `ctr` (2).
- Index is `pc[IDX+1:2]`; tag is `pc[31:IDX+2]`; `pc[1:0]` ignored.
- Lookup hit: entry at `fetch_pc` index has `valid=1` and a matching tag.
- Lookup outputs:
  - `pred_taken = bp_enable & hit & ctr[1]`.
  - `pred_target = hit ? target : fetch_pc + 4` (mod 2^32); independent of `bp_enable`.
- Update when `upd_valid=1`, with hit evaluated on `upd_pc`:
  - Hit, taken: `ctr` increments, saturating at 3; `target <= upd_target`.
  - Hit, not taken: `ctr` decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate (overwrite) entry — `valid=1`, `tag`, `target=upd_target`, `ctr=2'b10`.
  - Miss, not taken: no table change.
- Performance counters on `upd_valid=1`:
  - `br_count += 1`.
  - `mispred_count += upd_mispredict`.
  - Both wrap modulo 2^32.
- Flush: `bp_flush=1` clears every `valid` at the edge. It beats a same-cycle update/allocate, so the entry stays invalid. Counters are not affected by flush.
- `upd_*` other than `upd_valid` are don't-care when `upd_valid=0`.

## Timing

- Lookup is combinational from `fetch_pc` and registered state: 0-cycle latency.
- Update/allocate becomes visible to lookup on the cycle after the edge that samples `upd_valid`.
- Same-index lookup and update in one cycle: lookup returns the pre-update state.
- Reset (`rst_n=0` at an edge), regardless of in-flight update or flush:
  - all `valid=0`, all `ctr=2'b01`;
  - `br_count = mispred_count = 0`;
  - targets and tags don't-care.
- Outputs after reset: `pred_taken=0`, `pred_target=fetch_pc+4`.
- Reset asserted mid-operation discards that cycle's update and counter increment.
- No backpressure: one update per cycle is accepted unconditionally.

## Test plan

- **Reset:** hold `rst_n=0` 2 cycles, release, `fetch_pc=0x4000_0000` → `pred_taken=0`, `pred_target=0x4000_0004`, both counters 0.
- **Allocate:** update `pc=0x4000_0010`, taken, target `0x4000_0100`, then fetch `0x4000_0010` next cycle → `pred_taken=1`, `pred_target=0x4000_0100`. Same cycle as the update → `pred_taken=0`.
- **Saturation and hysteresis** (ENTRIES=16, after allocate):
  - 3 not-taken updates → ctr 0, `pred_taken=0`.
  - 1 taken → ctr 1, still 0.
  - 2nd taken → ctr 2, `pred_taken=1`.
  - 4 taken → ctr stays 3.
- **Aliasing:** allocate `0x4000_0010`, then update `0x4000_0050` (same index, different tag) taken target `0x4000_0200` → `0x4000_0010` misses (`pred_target=0x4000_0014`); `0x4000_0050` predicts `0x4000_0200`.
- **Flush and enable:**
  - Flush asserted with a simultaneous allocate → next-cycle lookup misses.
  - With `bp_enable=0` and a trained entry → `pred_taken=0`, `pred_target`=stored target.
- **Counters:** 5 updates with `upd_mispredict` = 1,0,1,1,0 → `br_count=5`, `mispred_count=3`. Preload near wrap (`0xFFFF_FFFF` + 1 update) → `br_count=0`. Reset mid-sequence → 0 next cycle.
